// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// opcodes, FSM state encoding, datapath select codes and control word.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_ADDR   = 4'd2,
        S_MEM_READ   = 4'd3,
        S_MEM_WB     = 4'd4,
        S_MEM_WRITE  = 4'd5,
        S_EXECUTE    = 4'd6,
        S_R_COMPLETE = 4'd7,
        S_BRANCH     = 4'd8,
        S_JUMP       = 4'd9,
        S_ADDI_EXEC  = 4'd10,
        S_ADDI_WB    = 4'd11,
        S_ILLEGAL    = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// Moore control-word decode: maps the FSM state to every datapath
// enable and select. Unused state codes decode to an all-zero word.
module control_output_decode
    import mips_defs::*;
(
    input  logic [3:0] state_i,
    output ctrl_t      ctrl_o
);

    // State to control word, everything defaults to zero
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_COMPLETE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl_o.illegal = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with a
// retired-instruction counter and illegal-opcode flag.
module mips_multicycle_control
    import mips_defs::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    output logic                   pc_write_en,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ALUOp,
    output logic [1:0]             PCSource,
    output logic                   illegal_op,
    output logic [3:0]             state,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    localparam logic [COUNT_WIDTH-1:0] ONE =
        {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   retire;
    ctrl_t                  dec_ctrl;
    ctrl_t                  ctrl;
    logic                   is_bne;

    control_output_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (dec_ctrl)
    );

    // State and counter registers, reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state selection and retirement detection
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXECUTE:   state_d = S_R_COMPLETE;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_COMPLETE,
            S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        count_d = retire ? count_q + ONE : count_q;
    end

    // Reset forces the whole control word quiet in its own cycle
    always_comb begin
        ctrl = reset ? '0 : dec_ctrl;
    end

    assign is_bne      = (opcode == OP_BNE);
    assign pc_write_en = ctrl.pc_write |
                         (ctrl.pc_write_cond & (zero ^ is_bne));
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign illegal_op  = ctrl.illegal;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule
